dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Load/store unit downstream of the pipelined core's memory stage: consumes MemWrite, ALUResult (address), WriteData and funct3, and returns ReadData.
- Converts byte, halfword and word accesses into word-aligned bus transactions with byte enables over a req/gnt/rvalid memory port of variable latency.
- Stalls the core while a transaction is outstanding.
- Flags misaligned accesses, illegal funct3 and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64, cycles spent in REQ+RESP before the access is aborted with a fault; must be >= 2.
- ADDR_W, 32, core/bus address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- core_req  in  1  memory-stage instruction is a load or store
- core_we  in  1  1=store, 0=load
- core_funct3  in  3  RISC-V funct3 of the load/store
- core_addr  in  ADDR_W  byte address (ALUResult)
- core_wdata  in  32  store data (WriteData)
- core_rdata  out  32  formatted load data (ReadData)
- stall  out  1  hold the pipeline
- misaligned  out  1  one-cycle pulse: misaligned access
- access_fault  out  1  one-cycle pulse: illegal funct3 or timeout
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted request this cycle
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address, bits[1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_rvalid  in  1  response/ack valid
- mem_rdata  in  32  read word

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE.
- Reset: state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_rdata, misaligned and access_fault all 0; timeout counter 0. Reset mid-transaction aborts it with no fault pulse; any late mem_rvalid received in IDLE is ignored.
- stall = core_req & (state != DONE). This is combinational; every other output is registered.
- IDLE, core_req=1:
  - Legal, aligned request: latch address/funct3/we and drive mem_* (registered) -> REQ.
  - Illegal funct3 (loads 011/110/111; stores 011-111): -> DONE with access_fault.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): -> DONE with misaligned=1.
  - Faulted accesses issue no bus request and return core_rdata=0.
- REQ: hold mem_req=1 and all mem_* stable until mem_gnt=1, then mem_req=0 on the next edge -> RESP.
- RESP: wait for mem_rvalid. On mem_rvalid=1: loads register the formatted data into core_rdata; stores ignore mem_rdata. -> DONE.
- Simultaneous gnt and rvalid are not legal; rvalid is only accepted in RESP.
- Timeout: a counter runs in REQ and RESP. When it reaches TIMEOUT_CYCLES-1: -> DONE, access_fault pulse, mem_req dropped, core_rdata=0.
- DONE: lasts one cycle with stall=0 and core_rdata valid; the fault pulses are asserted in this cycle. -> IDLE unconditionally. The next request is not accepted until IDLE, so back-to-back accesses each pay their full latency.
- Minimum latency: gnt in the first REQ cycle plus rvalid one cycle later gives stall high for 3 cycles (IDLE, REQ, RESP), with DONE on the 4th.
- Store formatting:
  - SB: be = 1<<addr[1:0], wdata = {4{b}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{h}}.
  - SW: be = 1111.
- Load formatting:
  - Shift mem_rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive mem_be = 1111.

Decomposition:
- Package rv_mem_pkg holds the funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and the state encoding (IDLE/REQ/RESP/DONE as 2-bit localparams).
- One combinational sub-module, lsu_align: store lane/byte-enable generation, load extract/extend, and the misalign/illegal checks.
- The FSM, timeout counter and output registers stay in dmem_access_unit.

Test Plan:
- LW at 0x100, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, stall high 3 cycles, core_rdata=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF_0000 -> core_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201, wdata=0x000000AB -> mem_addr=0x200, be=0010, mem_wdata=0xABABABAB, mem_we=1. SH at 0x202 -> be=1100.
- LW at 0x102 -> misaligned pulse, no mem_req. funct3=011 load -> access_fault, no mem_req. Both return core_rdata=0 with stall released after 1 cycle.
- gnt delayed 5 cycles -> mem_req and mem_addr stable throughout. With TIMEOUT_CYCLES=8 and rvalid never asserted -> access_fault after 8 cycles, mem_req=0.
- reset=0 asserted while in RESP -> IDLE next edge, all outputs 0, no fault pulse. A later rvalid is ignored and the next LW completes normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory access unit.
//   funct3 encodings of RISC-V loads/stores and the access FSM state type.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   Request side (core inputs): legality checks, byte enables, replicated
//   store data.
//   Response side (latched access): extract and extend the load result.
// Ports:
//   req_we, req_funct3, req_off  - incoming access (store flag, funct3, addr[1:0])
//   req_wdata                    - raw store data
//   be, wdata                    - byte enables / lane-replicated store data
//   misaligned, illegal          - access checks (illegal takes precedence)
//   ld_funct3, ld_off, bus_rdata - latched load info and returned bus word
//   ld_data                      - formatted load result
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      illegal = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
  end

  // Only meaningful for legal funct3; size comes from funct3[1:0].
  always_comb begin
    misaligned = 1'b0;
    if (!illegal) begin
      case (req_funct3[1:0])
        2'b01:   misaligned = req_off[0];
        2'b10:   misaligned = (req_off != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << req_off;
          wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be    = req_off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = req_wdata;
        end
      endcase
    end
  end

  assign shifted = bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      F3_W:    ld_data = shifted;
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store unit between the core's memory stage and a req/gnt/rvalid bus.
// Turns byte/half/word accesses into word-aligned bus transfers with byte
// enables, stalls the core while a transfer is outstanding and reports
// misaligned, illegal and timed-out accesses as one-cycle pulses.
// Ports:
//   clk, reset             - clock, synchronous active-low reset
//   core_req/we/funct3     - access request from the memory stage
//   core_addr, core_wdata  - byte address and store data
//   core_rdata             - formatted load data (valid in the release cycle)
//   stall                  - hold the pipeline (combinational)
//   misaligned, access_fault - fault pulses
//   mem_req/we/addr/be/wdata - registered bus request
//   mem_gnt, mem_rvalid, mem_rdata - bus handshake and read data
module dmem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              access_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state, state_n;
  logic [CNT_W-1:0] tcnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic        al_ill;
  logic [31:0] al_ldata;

  logic accept, flag_ill, flag_mis, tmo, fin, tmo_hit;

  lsu_align u_align (
    .req_we     (core_we),
    .req_funct3 (core_funct3),
    .req_off    (core_addr[1:0]),
    .req_wdata  (core_wdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .illegal    (al_ill),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .bus_rdata  (mem_rdata),
    .ld_data    (al_ldata)
  );

  assign stall   = core_req & (state != DONE);
  assign tmo_hit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Timeout takes priority over a gnt/rvalid arriving in the same cycle.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    flag_ill = 1'b0;
    flag_mis = 1'b0;
    tmo      = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          if (al_ill) begin
            flag_ill = 1'b1;
            state_n  = DONE;
          end else if (al_mis) begin
            flag_mis = 1'b1;
            state_n  = DONE;
          end else begin
            accept  = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = DONE;
        end else if (mem_gnt) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (tmo_hit) begin
          tmo     = 1'b1;
          state_n = DONE;
        end else if (mem_rvalid) begin
          fin     = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      core_rdata   <= '0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      state        <= state_n;
      misaligned   <= flag_mis;
      access_fault <= flag_ill | tmo;
      // Request is high exactly while the FSM sits in REQ.
      mem_req      <= (state_n == REQ);

      if (accept) begin
        f3_q      <= core_funct3;
        off_q     <= core_addr[1:0];
        we_q      <= core_we;
        mem_we    <= core_we;
        mem_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= al_be;
        mem_wdata <= core_we ? al_wdata : '0;
      end

      if (accept) begin
        tcnt <= '0;
      end else if ((state == REQ) || (state == RESP)) begin
        tcnt <= tcnt + CNT_W'(1);
      end else begin
        tcnt <= '0;
      end

      if (accept || flag_ill || flag_mis || tmo) begin
        core_rdata <= '0;
      end else if (fin) begin
        core_rdata <= we_q ? '0 : al_ldata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver plays both the core and a
// variable-latency memory, pushing expected completions and bus requests into
// queues; independent monitors pop and compare on the falling clock edge.
module tb_dmem_access_unit;

  localparam int unsigned TMO   = 8;
  localparam int unsigned NEVER = 1000;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        stall;
  logic        misaligned;
  logic        access_fault;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  dmem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_funct3  (core_funct3),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int unsigned stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Completion monitor: a cycle with core_req high and stall low releases the core.
  int unsigned stall_cnt = 0;
  always @(negedge clk) begin
    if (reset && core_req) begin
      if (stall) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: got release expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("core_rdata", core_rdata, e.rdata);
          check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          check("access_fault", {31'd0, access_fault}, {31'd0, e.flt});
          check("mem_req_in_done", {31'd0, mem_req}, 32'd0);
          check("stall_cycles", stall_cnt, e.stall);
        end
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // Bus monitor: every cycle of an active request must match the expected
  // transfer, which also enforces stability until the grant.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", mem_addr);
      end else begin
        check("mem_addr", mem_addr, bus_q[0].addr);
        check("mem_be", {28'd0, mem_be}, {28'd0, bus_q[0].be});
        check("mem_wdata", mem_wdata, bus_q[0].wdata);
        check("mem_we", {31'd0, mem_we}, {31'd0, bus_q[0].we});
      end
    end
    if (prev_req && !mem_req && bus_q.size() > 0) void'(bus_q.pop_front());
    prev_req = mem_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model from the architectural rules, then drive core + memory.
  // g: REQ cycle index of the grant; r: RESP cycle index of rvalid.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned g, input int unsigned r);
    exp_t        e;
    bus_t        b;
    logic        legal;
    logic        mis;
    int unsigned nbytes;
    int unsigned off;
    int unsigned n;
    logic [31:0] word;
    legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 1 << f3[1:0];
    off    = addr % 4;
    mis    = legal && (addr % nbytes != 0);
    n      = (legal && !mis) ? ((g + r + 2 < TMO) ? g + r + 2 : TMO) : 0;
    e.mis   = mis;
    e.flt   = !legal || (!mis && g + r + 2 >= TMO);
    e.stall = 1 + n;
    e.rdata = 32'd0;
    if (legal && !mis && !e.flt && !we) begin
      word = rd >> (8 * off);
      if (nbytes == 1) begin
        word = word & 32'hFF;
        if (!f3[2] && word[7]) word = word | 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        word = word & 32'hFFFF;
        if (!f3[2] && word[15]) word = word | 32'hFFFF_0000;
      end
      e.rdata = word;
    end
    exp_q.push_back(e);
    if (legal && !mis) begin
      b.addr = addr & ~32'h3;
      b.we   = we;
      if (we) begin
        b.be = 4'(((1 << nbytes) - 1) << off);
        for (int unsigned k = 0; k < 4; k++) b.wdata[8*k +: 8] = wd[8*(k % nbytes) +: 8];
      end else begin
        b.be    = 4'hF;
        b.wdata = 32'd0;
      end
      bus_q.push_back(b);
    end
    core_req    = 1'b1;
    core_we     = we;
    core_funct3 = f3;
    core_addr   = addr;
    core_wdata  = wd;
    for (int unsigned c = 0; c < n; c++) begin
      @(posedge clk); #1;
      mem_gnt = (c == g);
      if (c > g && (c - g - 1) == r) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    @(posedge clk); #1;
    core_req   = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    core_req    = 1'b0;
    core_we     = 1'b0;
    core_funct3 = 3'd0;
    core_addr   = 32'd0;
    core_wdata  = 32'd0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_core_rdata", core_rdata, 32'd0);
    check("rst_faults", {30'd0, misaligned, access_fault}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 2);
    do_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0, 1);
    do_txn(1'b1, 3'b000, 32'h201, 32'hAB, 32'h1234_5678, 0, 0);
    do_txn(1'b1, 3'b001, 32'h202, 32'hCAFE_1234, 32'h0, 2, 0);
    do_txn(1'b1, 3'b010, 32'h204, 32'h0102_0304, 32'h0, 0, 3);
    do_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
    do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    do_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);
    do_txn(1'b0, 3'b101, 32'h302, 32'h0, 32'h8001_7FFF, 5, 0);
    do_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, NEVER);
    do_txn(1'b0, 3'b010, 32'h404, 32'h0, 32'h0, NEVER, NEVER);
    do_txn(1'b0, 3'b010, 32'h408, 32'h0, 32'h5555_AAAA, 6, 0);
    do_txn(1'b0, 3'b010, 32'h40C, 32'h0, 32'h5555_AAAA, 5, 0);

    // Randomized traffic
    for (int unsigned i = 0; i < 300; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int unsigned g;
      int unsigned r;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 4 : 0));
      if (f3 == 3'd6) f3 = 3'd2;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'h3 >> (2 - ((f3[1:0] > 2) ? 2 : f3[1:0])));
      g  = $urandom_range(0, 4);
      r  = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 4);
      do_txn(1'($urandom), f3, a, $urandom, $urandom, g, r);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset while waiting for the response
    bus_q.push_back('{addr: 32'h500, be: 4'hF, wdata: 32'd0, we: 1'b0});
    core_req    = 1'b1;
    core_we     = 1'b0;
    core_funct3 = 3'b010;
    core_addr   = 32'h500;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt  = 1'b0;
    core_req = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_core_rdata", core_rdata, 32'd0);
    check("midrst_faults", {30'd0, misaligned, access_fault}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("late_rvalid_rdata", core_rdata, 32'd0);
    check("late_rvalid_faults", {30'd0, misaligned, access_fault}, 32'd0);
    do_txn(1'b0, 3'b010, 32'h600, 32'h0, 32'h2468_ACE0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("bus_q_drained", bus_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
